parity_tree_pipe: RTL and testbench
===================================

# parity_tree_pipe

Parametrised, pipelined XOR-reduction (parity) tree with a post-tree AND gate, per-word or per-frame accumulation, and a frame word counter. It generalises the fixed four-input XOR-then-AND structure to any power-of-two width with selectable pipeline register placement. It sits on datapath sideband logic and serves as a synthesis/timing regression block for XOR-tree balancing.

## Interface
Parameters:
- WIDTH, 32, data bits per word; power of two, ≥ 2.
- REG_EVERY, 1, number of XOR2 levels between pipeline registers; ≥ 1.
- CNT_W, 16, width of the frame word counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word qualifier.
- in_data  in  WIDTH  word to reduce.
- in_gate  in  1  AND operand applied to the word parity.
- in_sop  in  1  start of frame (mode 1).
- in_eop  in  1  end of frame (mode 1).
- in_mode  in  1  0 = per-word result, 1 = frame accumulation.
- out_valid  out  1  result strobe.
- out_parity  out  1  result bit.
- out_count  out  CNT_W  words in reported frame (mode 1); 1 in mode 0.
- out_err  out  1  one-cycle framing-error pulse.

## Operation
- Tree: LOG2W = log2(WIDTH) levels of XOR2, balanced. Register after every REG_EVERY levels; last level always registered. Tree stages P = ceil(LOG2W / REG_EVERY).
- Sideband (valid, gate, sop, eop, mode) is delayed through P matching registers; mode is per word, never sampled globally.
- Gate stage (final register): word result r = tree_parity & gate.
- Mode 0: out_valid = 1, out_parity = r, out_count = 1. Accumulator and frame state untouched.
- Mode 1, state IDLE / OPEN (frame_open flag), accumulator acc, counter cnt:
  - sop & eop: single-word frame; out_valid, out_parity = r, out_count = 1; stays IDLE.
  - sop (no eop) in IDLE: acc = r, cnt = 1, to OPEN; no output.
  - sop in OPEN: out_err pulse, discard old frame, acc = r, cnt = 1, stay OPEN.
  - mid word in OPEN: acc ^= r, cnt += 1 saturating at 2^CNT_W − 1.
  - eop in OPEN: out_valid, out_parity = acc ^ r, out_count = cnt + 1 (saturating); to IDLE.
  - eop in IDLE: out_err pulse and treated as single-word frame (outputs r, count 1).
  - mid word in IDLE: out_err pulse, word dropped, no output.
- Invalid words (bubbles) propagate with valid = 0 and change no state.
- out_parity and out_count hold last value while out_valid = 0.

## Timing
- Latency in_valid → out_valid: P + 1 cycles (WIDTH=32, REG_EVERY=1: 6; REG_EVERY≥5: 2).
- Throughput: one word per cycle, no backpressure; output order equals input order.
- out_err asserted in same cycle the offending word reaches the gate stage, one cycle wide.
- Reset (synchronous): all pipeline valid bits 0, frame_open 0, acc 0, cnt 0, out_valid 0, out_parity 0, out_count 0, out_err 0. Words in flight at reset are discarded; no output for them. Data pipeline registers need no reset.
- Reset mid-frame: frame abandoned silently (no out_err).

## Test plan
- WIDTH=32, REG_EVERY=1, mode 0: in_data=0x0000_0007, gate=1 at cycle 0 -> out_valid at cycle 6, out_parity=1, out_count=1; same word gate=0 -> out_parity=0.
- Back-to-back mode 0: 8 consecutive words 0x1,0x3,0x7,…,0xFF, gate=1 -> 8 consecutive out_valid cycles, parity 1,0,1,0,1,0,1,0.
- Mode 1 frame: sop 0x1, mid 0x3, eop 0x1, all gate=1 -> single out_valid 6 cycles after eop word, out_parity=0, out_count=3; mid word with gate=0 and data 0x2 -> parity 0, count 3.
- Single-word frame sop&eop with 0x8000_0000 -> out_parity=1, out_count=1, no out_err; eop in IDLE -> out_err pulse plus same result.
- Framing error: sop 0x1, sop 0x0, eop 0x0 -> one out_err pulse at second sop, out_parity=0, out_count=2.
- Reset mid-frame: sop + 2 words in flight, rst 1 cycle -> no out_valid/out_err afterwards; next frame sop 0x1 eop 0x0 -> out_parity=1, out_count=2. Repeat REG_EVERY=5 checking latency 2.

Source files
------------

// File: rtl/parity_tree_pipe_if.sv
// Word/frame input and parity result bundle for parity_tree_pipe.
// The master side drives words; the slave side (the tree) returns results.
interface parity_tree_pipe_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_gate;
   logic             in_sop;
   logic             in_eop;
   logic             in_mode;
   logic             out_valid;
   logic             out_parity;
   logic [CNT_W-1:0] out_count;
   logic             out_err;

   modport master (
      output in_valid, in_data, in_gate, in_sop, in_eop, in_mode,
      input  out_valid, out_parity, out_count, out_err
   );

   modport slave (
      input  in_valid, in_data, in_gate, in_sop, in_eop, in_mode,
      output out_valid, out_parity, out_count, out_err
   );
endinterface

// File: rtl/parity_tree_pipe.sv
// Pipelined balanced XOR-reduction tree with a gate stage that reports
// per-word parity or accumulates parity over sop/eop framed words.
module parity_tree_pipe #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned REG_EVERY = 1,
   parameter int unsigned CNT_W     = 16
) (
   input logic               clk,
   input logic               rst,
   parity_tree_pipe_if.slave bus
);
   localparam int unsigned LOG2W = $clog2(WIDTH);
   localparam int unsigned P     = (LOG2W + REG_EVERY - 1) / REG_EVERY;
   localparam int unsigned NODES = 2 * WIDTH - 1;
   localparam int unsigned SB_W  = 5;

   // Flat node store: leaves first, then each level, root in the top bit.
   wire [NODES-1:0] node;
   assign node[WIDTH-1:0] = bus.in_data;

   for (genvar l = 0; l < LOG2W; l++) begin : g_lvl
      localparam int unsigned N_OUT   = WIDTH >> (l + 1);
      localparam int unsigned IN_OFF  = 2 * WIDTH - 4 * N_OUT;
      localparam int unsigned OUT_OFF = 2 * WIDTH - 2 * N_OUT;
      logic [N_OUT-1:0] x;
      for (genvar i = 0; i < N_OUT; i++) begin : g_xor
         assign x[i] = node[IN_OFF + 2*i] ^ node[IN_OFF + 2*i + 1];
      end
      if (((l + 1) % REG_EVERY == 0) || (l == LOG2W - 1)) begin : g_reg
         logic [N_OUT-1:0] q;
         always_ff @(posedge clk) q <= x;
         assign node[OUT_OFF +: N_OUT] = q;
      end else begin : g_comb
         assign node[OUT_OFF +: N_OUT] = x;
      end
   end

   // Sideband delay line, one register per tree stage.
   logic [SB_W-1:0] sb_q [P];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < P; s++) sb_q[s] <= '0;
      end else begin
         sb_q[0] <= {bus.in_valid, bus.in_gate, bus.in_sop, bus.in_eop, bus.in_mode};
         for (int unsigned s = 1; s < P; s++) sb_q[s] <= sb_q[s-1];
      end
   end

   logic s_valid, s_gate, s_sop, s_eop, s_mode, r;
   assign {s_valid, s_gate, s_sop, s_eop, s_mode} = sb_q[P-1];
   assign r = node[NODES-1] & s_gate;

   typedef enum logic {IDLE, OPEN} state_t;
   state_t           state;
   logic             acc;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             res_valid;
   logic             res_parity;
   logic             res_err;
   logic [CNT_W-1:0] res_count;

   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   // Gate stage and frame accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         acc        <= 1'b0;
         cnt        <= '0;
         res_valid  <= 1'b0;
         res_parity <= 1'b0;
         res_count  <= '0;
         res_err    <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         res_err   <= 1'b0;
         if (s_valid) begin
            if (!s_mode) begin
               res_valid  <= 1'b1;
               res_parity <= r;
               res_count  <= CNT_W'(1);
            end else if (s_sop && s_eop) begin
               // A frame still open is abandoned and flagged.
               res_err    <= (state == OPEN);
               res_valid  <= 1'b1;
               res_parity <= r;
               res_count  <= CNT_W'(1);
               state      <= IDLE;
            end else if (s_sop) begin
               res_err <= (state == OPEN);
               acc     <= r;
               cnt     <= CNT_W'(1);
               state   <= OPEN;
            end else if (s_eop) begin
               res_valid <= 1'b1;
               state     <= IDLE;
               if (state == OPEN) begin
                  res_parity <= acc ^ r;
                  res_count  <= cnt_inc;
               end else begin
                  res_err    <= 1'b1;
                  res_parity <= r;
                  res_count  <= CNT_W'(1);
               end
            end else if (state == OPEN) begin
               acc <= acc ^ r;
               cnt <= cnt_inc;
            end else begin
               res_err <= 1'b1;
            end
         end
      end
   end

   assign bus.out_valid  = res_valid;
   assign bus.out_parity = res_parity;
   assign bus.out_count  = res_count;
   assign bus.out_err    = res_err;
endmodule

// File: tb/tb_parity_tree_pipe.sv
// Bench for parity_tree_pipe: two instances (REG_EVERY 1 and 5) share stimulus
// and are compared event-by-event against a word-level frame model.
module tb_parity_tree_pipe;
   localparam int unsigned W       = 32;
   localparam int unsigned CW      = 16;
   localparam int unsigned CNT_MAX = (1 << CW) - 1;

   typedef struct packed {
      int unsigned   cyc;
      logic          valid;
      logic          parity;
      logic          err;
      logic [CW-1:0] count;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_gate, in_sop, in_eop, in_mode;
   logic [W-1:0] in_data;
   int unsigned  cyc = 0;
   int           n_run = 0;
   int           n_fail = 0;

   ev_t got_q  [2][$];
   ev_t want_q [2][$];

   bit          m_open;
   bit          m_acc;
   int unsigned m_cnt;

   parity_tree_pipe_if #(.WIDTH(W), .CNT_W(CW)) b1 ();
   parity_tree_pipe_if #(.WIDTH(W), .CNT_W(CW)) b5 ();

   assign b1.in_valid = in_valid;  assign b5.in_valid = in_valid;
   assign b1.in_data  = in_data;   assign b5.in_data  = in_data;
   assign b1.in_gate  = in_gate;   assign b5.in_gate  = in_gate;
   assign b1.in_sop   = in_sop;    assign b5.in_sop   = in_sop;
   assign b1.in_eop   = in_eop;    assign b5.in_eop   = in_eop;
   assign b1.in_mode  = in_mode;   assign b5.in_mode  = in_mode;

   parity_tree_pipe #(.WIDTH(W), .REG_EVERY(1), .CNT_W(CW)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   parity_tree_pipe #(.WIDTH(W), .REG_EVERY(5), .CNT_W(CW)) dut5 (.clk(clk), .rst(rst), .bus(b5));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (b1.out_valid || b1.out_err)
         got_q[0].push_back('{cyc, b1.out_valid, b1.out_parity, b1.out_err, b1.out_count});
      if (b5.out_valid || b5.out_err)
         got_q[1].push_back('{cyc, b5.out_valid, b5.out_parity, b5.out_err, b5.out_count});
   end

   function automatic int unsigned lat(int k);
      return (k == 0) ? 6 : 2;
   endfunction

   function automatic int unsigned re_of(int k);
      return (k == 0) ? 1 : 5;
   endfunction

   function automatic bit same(ev_t a, ev_t b);
      return (a.cyc == b.cyc) && (a.valid === b.valid) && (a.err === b.err) &&
             (!b.valid || ((a.parity === b.parity) && (a.count === b.count)));
   endfunction

   function automatic string fmt(ev_t e);
      return $sformatf("cyc=%0d v=%0b p=%0b n=%0d e=%0b", e.cyc, e.valid, e.parity, e.count, e.err);
   endfunction

   // Frame rules applied at word granularity; expected output cycle = issue + latency.
   function automatic void model(logic [W-1:0] d, bit g, bit s, bit e, bit m);
      bit  r  = (($countones(d) % 2) == 1) && g;
      ev_t ev = '0;
      if (!m) begin
         ev.valid = 1; ev.parity = r; ev.count = CW'(1);
      end else if (s && e) begin
         ev.err = m_open; ev.valid = 1; ev.parity = r; ev.count = CW'(1);
         m_open = 0;
      end else if (s) begin
         ev.err = m_open; m_open = 1; m_acc = r; m_cnt = 1;
      end else if (e) begin
         ev.valid = 1;
         if (m_open) begin
            ev.parity = m_acc ^ r;
            ev.count  = CW'((m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1);
         end else begin
            ev.err = 1; ev.parity = r; ev.count = CW'(1);
         end
         m_open = 0;
      end else if (m_open) begin
         m_acc = m_acc ^ r;
         m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end else begin
         ev.err = 1;
      end
      if (ev.valid || ev.err) begin
         for (int k = 0; k < 2; k++) begin
            ev.cyc = cyc + lat(k);
            want_q[k].push_back(ev);
         end
      end
   endfunction

   task automatic drive(input bit v, input logic [W-1:0] d, input bit g, input bit s,
                        input bit e, input bit m);
      in_valid = v; in_data = d; in_gate = g; in_sop = s; in_eop = e; in_mode = m;
      if (v) model(d, g, s, e, m);
      @(posedge clk); #1;
   endtask

   // Bubbles carry random sideband to show they change nothing.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(0, W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic start();
      for (int k = 0; k < 2; k++) begin
         got_q[k].delete();
         want_q[k].delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 0; in_data = '0; in_gate = 0; in_sop = 0; in_eop = 0; in_mode = 0;
      m_open = 0; m_acc = 0; m_cnt = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n_run += 4;
      if ({b1.out_valid, b1.out_err, b5.out_valid, b5.out_err} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset strobes: got %b want 0000", {b1.out_valid, b1.out_err, b5.out_valid, b5.out_err});
      end
      if (b1.out_parity !== 1'b0) begin n_fail++; $display("FAIL reset parity RE=1: got %b want 0", b1.out_parity); end
      if (b5.out_parity !== 1'b0) begin n_fail++; $display("FAIL reset parity RE=5: got %b want 0", b5.out_parity); end
      if ({b1.out_count, b5.out_count} !== '0) begin
         n_fail++;
         $display("FAIL reset count: got %0d/%0d want 0/0", b1.out_count, b5.out_count);
      end
   endtask

   task automatic test_mode0();
      start();
      drive(1, 32'h0000_0007, 1, 0, 0, 0);
      drive(1, 32'h0000_0007, 0, 0, 0, 0);
      drive(1, 32'h0000_0001, 1, 1, 0, 0);
      idle(8);
      n_run += 2;
      if ({b1.out_parity, b5.out_parity} !== 2'b11) begin
         n_fail++; $display("FAIL mode0 hold parity: got %b want 11", {b1.out_parity, b5.out_parity});
      end
      if ({b1.out_count, b5.out_count} !== {CW'(1), CW'(1)}) begin
         n_fail++; $display("FAIL mode0 hold count: got %0d/%0d want 1/1", b1.out_count, b5.out_count);
      end
      for (int k = 0; k < 2; k++) begin
         n_run++;
         if (got_q[k].size() != want_q[k].size()) begin
            n_fail++; $display("FAIL mode0 RE=%0d events: got %0d want %0d", re_of(k), got_q[k].size(), want_q[k].size());
         end
         for (int i = 0; i < want_q[k].size() && i < got_q[k].size(); i++) begin
            n_run++;
            if (!same(got_q[k][i], want_q[k][i])) begin
               n_fail++; $display("FAIL mode0 RE=%0d ev%0d: got %s want %s", re_of(k), i, fmt(got_q[k][i]), fmt(want_q[k][i]));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      start();
      for (int i = 0; i < 8; i++) drive(1, W'((64'd1 << (i + 1)) - 1), 1, 0, 0, 0);
      idle(8);
      for (int k = 0; k < 2; k++) begin
         n_run++;
         if (got_q[k].size() != want_q[k].size()) begin
            n_fail++; $display("FAIL b2b RE=%0d events: got %0d want %0d", re_of(k), got_q[k].size(), want_q[k].size());
         end
         for (int i = 0; i < want_q[k].size() && i < got_q[k].size(); i++) begin
            n_run++;
            if (!same(got_q[k][i], want_q[k][i])) begin
               n_fail++; $display("FAIL b2b RE=%0d ev%0d: got %s want %s", re_of(k), i, fmt(got_q[k][i]), fmt(want_q[k][i]));
            end
         end
      end
   endtask

   task automatic test_frame();
      start();
      drive(1, 32'h1, 1, 1, 0, 1);
      drive(1, 32'h3, 1, 0, 0, 1);
      drive(1, 32'h1, 1, 0, 1, 1);
      idle(2);
      drive(1, 32'h1, 1, 1, 0, 1);
      drive(1, 32'h2, 0, 0, 0, 1);
      drive(0, 32'hFFFF_FFFF, 1, 0, 1, 1);
      drive(1, 32'h1, 1, 0, 1, 1);
      drive(1, 32'h8000_0000, 1, 1, 1, 1);
      drive(1, 32'h8000_0000, 1, 0, 1, 1);
      idle(8);
      for (int k = 0; k < 2; k++) begin
         n_run++;
         if (got_q[k].size() != want_q[k].size()) begin
            n_fail++; $display("FAIL frame RE=%0d events: got %0d want %0d", re_of(k), got_q[k].size(), want_q[k].size());
         end
         for (int i = 0; i < want_q[k].size() && i < got_q[k].size(); i++) begin
            n_run++;
            if (!same(got_q[k][i], want_q[k][i])) begin
               n_fail++; $display("FAIL frame RE=%0d ev%0d: got %s want %s", re_of(k), i, fmt(got_q[k][i]), fmt(want_q[k][i]));
            end
         end
      end
   endtask

   task automatic test_framing_error();
      start();
      drive(1, 32'h1, 1, 1, 0, 1);
      drive(1, 32'h0, 1, 1, 0, 1);
      drive(1, 32'h0, 1, 0, 1, 1);
      drive(1, 32'h1, 1, 0, 0, 1);
      idle(8);
      for (int k = 0; k < 2; k++) begin
         n_run++;
         if (got_q[k].size() != want_q[k].size()) begin
            n_fail++; $display("FAIL framing RE=%0d events: got %0d want %0d", re_of(k), got_q[k].size(), want_q[k].size());
         end
         for (int i = 0; i < want_q[k].size() && i < got_q[k].size(); i++) begin
            n_run++;
            if (!same(got_q[k][i], want_q[k][i])) begin
               n_fail++; $display("FAIL framing RE=%0d ev%0d: got %s want %s", re_of(k), i, fmt(got_q[k][i]), fmt(want_q[k][i]));
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int unsigned rcyc;
      start();
      drive(1, 32'h1, 1, 1, 0, 1);
      drive(1, 32'h3, 1, 0, 0, 1);
      drive(1, 32'h7, 1, 0, 0, 1);
      rst = 1'b1; in_valid = 1'b0;
      rcyc = cyc;
      @(posedge clk); #1;
      rst = 1'b0;
      m_open = 0; m_acc = 0; m_cnt = 0;
      for (int k = 0; k < 2; k++)
         while (want_q[k].size() > 0 && want_q[k][$].cyc > rcyc) void'(want_q[k].pop_back());
      drive(1, 32'h1, 1, 1, 0, 1);
      drive(1, 32'h0, 1, 0, 1, 1);
      idle(8);
      for (int k = 0; k < 2; k++) begin
         n_run++;
         if (got_q[k].size() != want_q[k].size()) begin
            n_fail++; $display("FAIL rst_mid RE=%0d events: got %0d want %0d", re_of(k), got_q[k].size(), want_q[k].size());
         end
         for (int i = 0; i < want_q[k].size() && i < got_q[k].size(); i++) begin
            n_run++;
            if (!same(got_q[k][i], want_q[k][i])) begin
               n_fail++; $display("FAIL rst_mid RE=%0d ev%0d: got %s want %s", re_of(k), i, fmt(got_q[k][i]), fmt(want_q[k][i]));
            end
         end
      end
   endtask

   task automatic test_random();
      start();
      for (int n = 0; n < 400; n++)
         drive(($urandom % 4) != 0, W'($urandom), ($urandom % 4) != 0, ($urandom % 4) == 0,
               ($urandom % 4) == 0, ($urandom % 3) != 0);
      idle(8);
      for (int k = 0; k < 2; k++) begin
         n_run++;
         if (got_q[k].size() != want_q[k].size()) begin
            n_fail++; $display("FAIL random RE=%0d events: got %0d want %0d", re_of(k), got_q[k].size(), want_q[k].size());
         end
         for (int i = 0; i < want_q[k].size() && i < got_q[k].size(); i++) begin
            n_run++;
            if (!same(got_q[k][i], want_q[k][i])) begin
               n_fail++; $display("FAIL random RE=%0d ev%0d: got %s want %s", re_of(k), i, fmt(got_q[k][i]), fmt(want_q[k][i]));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_back_to_back();
      test_frame();
      test_framing_error();
      test_reset_mid_frame();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
